word_serializer: RTL and testbench



---
 rtl/word_serializer_pkg.sv | 17 +
 rtl/shift_reg_piso.sv | 39 +++
 rtl/word_serializer.sv | 103 ++++++++++
 tb/tb_word_serializer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/word_serializer_pkg.sv
// Shared constants for the word serializer: FSM state encoding and
// counter width helpers used by the top module and its shift register.
package word_serializer_pkg;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_SHIFT = 2'b01;
  localparam logic [1:0] S_GAP   = 2'b10;

  // The gap counter covers idle gaps of 0..15 cycles.
  localparam int GAP_CNT_W = 4;

  // Bit counter width: enough bits to hold WIDTH-1, never narrower than 1.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/shift_reg_piso.sv
// Parallel-in serial-out shift register. A load takes priority over a
// shift, and the bit at the output end is exposed combinationally.
module shift_reg_piso
  import word_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  output logic             out_bit
);

  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shifted;

  if (MSB_FIRST) begin : g_msb_first
    assign shifted = {shreg[WIDTH-2:0], 1'b0};
    assign out_bit = shreg[WIDTH-1];
  end else begin : g_lsb_first
    assign shifted = {1'b0, shreg[WIDTH-1:1]};
    assign out_bit = shreg[0];
  end

  // Hold, load a new word, or move the next bit toward the output end.
  always_ff @(posedge clock) begin
    if (reset) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= load_data;
    end else if (shift) begin
      shreg <= shifted;
    end
  end

endmodule

// File: rtl/word_serializer.sv
// Word serializer: accepts one word per handshake, emits it one bit per
// clock with x_valid, then holds the line at IDLE_BIT for GAP cycles.
// All outputs depend only on registered state, never on load_valid.
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP       = 0,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             x_out,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic HAS_GAP = (GAP > 0);
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD = (GAP > 0) ? GAP_CNT_W'(GAP - 1) : '0;

  logic [1:0]           state;
  logic [CW-1:0]        bit_cnt;
  logic [GAP_CNT_W-1:0] gap_cnt;
  logic                 handshake;
  logic                 last_bit;
  logic                 gap_end;
  logic                 shift_en;
  logic                 data_bit;

  assign last_bit   = (state == S_SHIFT) && (bit_cnt == '0);
  assign gap_end    = (state == S_GAP) && (gap_cnt == '0);
  assign load_ready = (state == S_IDLE) || (last_bit && !HAS_GAP) || gap_end;
  assign handshake  = load_valid && load_ready;
  assign shift_en   = (state == S_SHIFT);

  assign x_valid = (state == S_SHIFT);
  assign x_out   = (state == S_SHIFT) ? data_bit : IDLE_BIT;
  assign busy    = (state != S_IDLE);
  assign done    = last_bit;

  shift_reg_piso #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clock     (clock),
    .reset     (reset),
    .load      (handshake),
    .load_data (load_data),
    .shift     (shift_en),
    .out_bit   (data_bit)
  );

  // Sequence IDLE -> SHIFT -> (GAP) -> IDLE/SHIFT, reloading counters on each transition.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (handshake) begin
            state   <= S_SHIFT;
            bit_cnt <= LAST_CNT;
          end
        end
        S_SHIFT: begin
          if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - CW'(1);
          end else if (HAS_GAP) begin
            state   <= S_GAP;
            gap_cnt <= GAP_LOAD;
          end else if (handshake) begin
            bit_cnt <= LAST_CNT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_GAP: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GAP_CNT_W'(1);
          end else if (handshake) begin
            state   <= S_SHIFT;
            bit_cnt <= LAST_CNT;
          end else begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench for word_serializer. Two instances run side by side:
// dut0 is MSB-first with no gap, dut1 is LSB-first with a 3-cycle gap and
// IDLE_BIT = 1. A cycle-level model describes each word as a timeline of
// WIDTH data cycles followed by GAP idle cycles.
module tb_word_serializer;

  logic       clock = 1'b0;
  logic       reset;
  logic       lv  [2];
  logic [7:0] ld  [2];
  logic       rdy [2];
  logic       xo  [2];
  logic       xv  [2];
  logic       bz  [2];
  logic       dn  [2];

  int errors = 0;
  int checks = 0;

  // Model: a word in flight sits at position k (1..WIDTH+GAP) of its timeline.
  logic       m_active [2] = '{1'b0, 1'b0};
  int         m_k      [2] = '{0, 0};
  logic [7:0] m_word   [2] = '{8'h00, 8'h00};
  logic       model_on = 1'b0;

  always #5 clock = ~clock;

  word_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(0), .IDLE_BIT(1'b0)) dut0 (
    .clock(clock), .reset(reset), .load_valid(lv[0]), .load_data(ld[0]),
    .load_ready(rdy[0]), .x_out(xo[0]), .x_valid(xv[0]), .busy(bz[0]), .done(dn[0]));

  word_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP(3), .IDLE_BIT(1'b1)) dut1 (
    .clock(clock), .reset(reset), .load_valid(lv[1]), .load_data(ld[1]),
    .load_ready(rdy[1]), .x_out(xo[1]), .x_valid(xv[1]), .busy(bz[1]), .done(dn[1]));

  function automatic int gap_of(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  function automatic int period_of(input int i);
    return 8 + gap_of(i);
  endfunction

  function automatic logic m_ready(input int i);
    return !m_active[i] || (m_k[i] == period_of(i));
  endfunction

  function automatic logic m_xvalid(input int i);
    return m_active[i] && (m_k[i] <= 8);
  endfunction

  function automatic logic m_xout(input int i);
    if (m_xvalid(i)) begin
      if (i == 0) return m_word[i][8 - m_k[i]];
      return m_word[i][m_k[i] - 1];
    end
    return (i == 0) ? 1'b0 : 1'b1;
  endfunction

  function automatic logic m_done(input int i);
    return m_active[i] && (m_k[i] == 8);
  endfunction

  // Advance the model timeline on every rising edge.
  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_active[i] <= 1'b0;
        m_k[i]      <= 0;
      end else if (m_ready(i) && lv[i]) begin
        m_active[i] <= 1'b1;
        m_k[i]      <= 1;
        m_word[i]   <= ld[i];
      end else if (m_active[i]) begin
        if (m_k[i] == period_of(i)) m_active[i] <= 1'b0;
        else m_k[i] <= m_k[i] + 1;
      end
    end
    if (reset) model_on <= 1'b1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus();
    @(posedge clock);
    #2;
  endtask

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clock) begin
    if (model_on) begin
      for (int i = 0; i < 2; i++) begin
        checkOutput($sformatf("dut%0d load_ready", i), {31'd0, rdy[i]}, {31'd0, m_ready(i)});
        checkOutput($sformatf("dut%0d x_valid", i), {31'd0, xv[i]}, {31'd0, m_xvalid(i)});
        checkOutput($sformatf("dut%0d x_out", i), {31'd0, xo[i]}, {31'd0, m_xout(i)});
        checkOutput($sformatf("dut%0d busy", i), {31'd0, bz[i]}, {31'd0, m_active[i]});
        checkOutput($sformatf("dut%0d done", i), {31'd0, dn[i]}, {31'd0, m_done(i)});
      end
    end
  end

  logic [7:0]  seq;
  logic [15:0] seq16;
  int rc, vc, dcnt, dpos, gl, gi, v12;

  initial begin
    reset = 1'b1;
    lv[0] = 1'b0; lv[1] = 1'b0;
    ld[0] = 8'h00; ld[1] = 8'h00;
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b0;

    // Reset then idle for 10 cycles.
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      checkOutput("idle load_ready", {31'd0, rdy[0]}, 32'd1);
      checkOutput("idle x_valid", {31'd0, xv[0]}, 32'd0);
      checkOutput("idle x_out", {31'd0, xo[0]}, 32'd0);
      checkOutput("idle busy", {31'd0, bz[0]}, 32'd0);
      applyStimulus();
    end

    // Single word 8'hA5, MSB first.
    lv[0] = 1'b1; ld[0] = 8'hA5;
    applyStimulus();
    lv[0] = 1'b0;
    seq = 8'h00; vc = 0; dcnt = 0; dpos = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      seq = {seq[6:0], xo[0]};
      vc += int'(xv[0]);
      if (dn[0]) begin dcnt++; dpos = c; end
      applyStimulus();
    end
    checkOutput("a5 bits", {24'd0, seq}, 32'hA5);
    checkOutput("a5 valid count", vc, 8);
    checkOutput("a5 done count", dcnt, 1);
    checkOutput("a5 done cycle", dpos, 8);

    // LSB first 8'h0E on dut1: bits 0,1,1,1,0,0,0,0.
    lv[1] = 1'b1; ld[1] = 8'h0E;
    applyStimulus();
    lv[1] = 1'b0;
    seq = 8'h00;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      seq = {seq[6:0], xo[1]};
      applyStimulus();
    end
    checkOutput("lsb bits", {24'd0, seq}, 32'h70);
    repeat (4) applyStimulus();

    // Back-to-back FF then 00 with GAP = 0.
    lv[0] = 1'b1; ld[0] = 8'hFF;
    rc = 0; vc = 0; seq16 = 16'h0000;
    @(negedge clock);
    rc += int'(rdy[0]);
    applyStimulus();
    ld[0] = 8'h00;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clock);
      if (c <= 15) rc += int'(rdy[0]);
      vc += int'(xv[0]);
      seq16 = {seq16[14:0], xo[0]};
      applyStimulus();
      if (c == 8) lv[0] = 1'b0;
    end
    checkOutput("b2b ready count", rc, 2);
    checkOutput("b2b valid count", vc, 16);
    checkOutput("b2b bits", {16'd0, seq16}, 32'hFF00);
    repeat (2) applyStimulus();

    // Gap insertion on dut1: two words 3C then C5.
    lv[1] = 1'b1; ld[1] = 8'h3C;
    rc = 0; gl = 0; gi = 0; v12 = 0; seq = 8'h00;
    @(negedge clock);
    applyStimulus();
    ld[1] = 8'hC5;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clock);
      if (c >= 9 && c <= 11) begin
        gl += int'(!xv[1]);
        gi += int'(xo[1] == 1'b1);
      end
      if (c <= 19) rc += int'(rdy[1]);
      if (c == 12) v12 = int'(xv[1]);
      if (c >= 12 && c <= 19) seq = {xo[1], seq[7:1]};
      applyStimulus();
      if (c == 11) lv[1] = 1'b0;
    end
    checkOutput("gap low cycles", gl, 3);
    checkOutput("gap idle bit", gi, 3);
    checkOutput("gap ready count", rc, 1);
    checkOutput("gap resume valid", v12, 1);
    checkOutput("gap second word", {24'd0, seq}, 32'hC5);
    repeat (2) applyStimulus();

    // Mid-word reset during bit 4 of A5, then 81 serializes cleanly.
    lv[0] = 1'b1; ld[0] = 8'hA5;
    applyStimulus();
    lv[0] = 1'b0;
    dcnt = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clock);
      dcnt += int'(dn[0]);
      if (c == 4) reset = 1'b1;
      applyStimulus();
    end
    reset = 1'b0;
    @(negedge clock);
    checkOutput("midreset x_valid", {31'd0, xv[0]}, 32'd0);
    checkOutput("midreset busy", {31'd0, bz[0]}, 32'd0);
    dcnt += int'(dn[0]);
    applyStimulus();
    checkOutput("midreset no done", dcnt, 0);
    lv[0] = 1'b1; ld[0] = 8'h81;
    applyStimulus();
    lv[0] = 1'b0;
    seq = 8'h00; dpos = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      seq = {seq[6:0], xo[0]};
      if (dn[0]) dpos = c;
      applyStimulus();
    end
    checkOutput("after reset bits", {24'd0, seq}, 32'h81);
    checkOutput("after reset done cycle", dpos, 8);

    // Reset on the same edge as a handshake wins.
    lv[0] = 1'b1; ld[0] = 8'hFF; reset = 1'b1;
    applyStimulus();
    reset = 1'b0; lv[0] = 1'b0;
    @(negedge clock);
    checkOutput("reset wins busy", {31'd0, bz[0]}, 32'd0);
    checkOutput("reset wins x_valid", {31'd0, xv[0]}, 32'd0);
    applyStimulus();

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        lv[i] = (($urandom % 4) != 0);
        ld[i] = 8'($urandom);
      end
      reset = (($urandom % 150) == 0);
      applyStimulus();
    end
    reset = 1'b0; lv[0] = 1'b0; lv[1] = 1'b0;
    repeat (20) applyStimulus();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
